// File: rtl/ppa_pipe_adder.sv
// Pipelined Brent-Kung prefix adder/subtractor, any power-of-two WIDTH, STAGES register boundaries.
// Define PPA_OVF_EN to add the registered signed-overflow output `ovf`.
module ppa_pipe_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef PPA_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int LOGW = $clog2(WIDTH);
  localparam int LVLS = 2*LOGW - 1;
  localparam int POST = LVLS + 1;

  // po: original propagate (becomes the sum after post), p/g: running group terms, c: carry-in node
  typedef struct packed {
    logic [WIDTH-1:0] po;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g;
    logic             c;
  } node_t;

  function automatic int bnd_lvl(input int k);
    return (k*(LVLS+2))/STAGES - 1;
  endfunction

  // Register boundary index that follows level lvl, 0 when the level output is a plain wire
  function automatic int bnd_at(input int lvl);
    int r;
    r = 0;
    for (int k = 1; k <= STAGES; k++)
      if (bnd_lvl(k) == lvl) r = k;
    return r;
  endfunction

  function automatic node_t pre_level(input logic [WIDTH-1:0] a_i, input logic [WIDTH-1:0] b_i,
                                      input logic cin_i, input logic sub_i);
    node_t            y;
    logic [WIDTH-1:0] bp;
    bp     = sub_i ? ~b_i : b_i;
    y.c    = sub_i | cin_i;
    y.p    = a_i ^ bp;
    y.po   = y.p;
    y.g    = a_i & bp;
    // Carry-in folded into bit 0 so every prefix G_i already includes it
    y.g[0] = y.g[0] | (y.p[0] & y.c);
    return y;
  endfunction

  function automatic node_t cell_level(input int t, input node_t x);
    node_t            y;
    logic [WIDTH-1:0] m;
    int               d;
    y = x;
    m = '0;
    if (t == POST) begin
      y.po = x.po ^ {x.g[WIDTH-2:0], x.c};
    end else begin
      d = (t <= LOGW) ? (1 << (t-1)) : (1 << (2*LOGW-1-t));
      for (int i = 0; i < WIDTH; i++) begin
        if (t <= LOGW) m[i] = ((i+1) % (2*d)) == 0;
        else           m[i] = (((i+1) % (2*d)) == d) && (i+1 > d);
      end
      y.g = x.g | (m & x.p & (x.g << d));
      y.p = x.p & (~m | (x.p << d));
    end
    return y;
  endfunction

  logic [STAGES:1]   vld_pipe;
  logic [STAGES:0]   vld_nxt;
  logic [STAGES+1:1] adv;

  // Stage k advances if it is empty or everything downstream advances
  always_comb begin
    adv = '0;
    adv[STAGES+1] = out_ready;
    for (int k = STAGES; k >= 1; k--)
      adv[k] = !vld_pipe[k] || adv[k+1];
  end

  assign vld_nxt   = {vld_pipe, in_valid};
  assign in_ready  = adv[1];
  assign out_valid = vld_pipe[STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
    end else begin
      for (int k = 1; k <= STAGES; k++)
        if (adv[k]) vld_pipe[k] <= vld_nxt[k-1];
    end
  end

  for (genvar t = 0; t <= POST; t++) begin : g_lvl
    localparam int BK = bnd_at(t);
    node_t lo;
    node_t nxt;
    if (t == 0) begin : g_pre
      assign lo = pre_level(a, b, cin, sub);
    end else begin : g_cell
      assign lo = cell_level(t, g_lvl[t-1].nxt);
    end
    if (BK != 0) begin : g_reg
      node_t q;
      always_ff @(posedge clk)
        if (adv[BK]) q <= lo;
      assign nxt = q;
    end else begin : g_wire
      assign nxt = lo;
    end
  end

  node_t fin;
  logic  unused_fin;
  assign fin        = g_lvl[POST].nxt;
  assign sum        = fin.po;
  assign cout       = fin.g[WIDTH-1];
  assign unused_fin = ^{fin.p, fin.g[WIDTH-2:0], fin.c};
`ifdef PPA_OVF_EN
  assign ovf        = fin.g[WIDTH-1] ^ fin.g[WIDTH-2];
`endif

endmodule

// File: tb/tb_ppa_pipe_adder.sv
// Scoreboard bench for ppa_pipe_adder: W16/S2 directed scenarios plus W8/S1 and W64/S13 random sweeps.
module tb_ppa_pipe_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  int n_checks = 0;
  int n_fail   = 0;
  int n_ret16 = 0, n_ret8 = 0, n_ret64 = 0;
  exp_t q16[$], q8[$], q64[$];

  logic        iv16, ir16, cin16, sub16, ov16, ordy16, co16;
  logic [15:0] a16, b16, s16;
  logic        iv8, ir8, cin8, sub8, ov8, ordy8, co8;
  logic [7:0]  a8, b8, s8;
  logic        iv64, ir64, cin64, sub64, ov64, ordy64, co64;
  logic [63:0] a64, b64, s64;
`ifdef PPA_OVF_EN
  logic of16, of8, of64;
`endif

  ppa_pipe_adder #(.WIDTH(16), .STAGES(2)) u16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .cin(cin16), .sub(sub16), .out_valid(ov16), .out_ready(ordy16), .sum(s16), .cout(co16)
`ifdef PPA_OVF_EN
    , .ovf(of16)
`endif
  );

  ppa_pipe_adder #(.WIDTH(8), .STAGES(1)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .cin(cin8), .sub(sub8), .out_valid(ov8), .out_ready(ordy8), .sum(s8), .cout(co8)
`ifdef PPA_OVF_EN
    , .ovf(of8)
`endif
  );

  ppa_pipe_adder #(.WIDTH(64), .STAGES(13)) u64 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv64), .in_ready(ir64), .a(a64), .b(b64),
    .cin(cin64), .sub(sub64), .out_valid(ov64), .out_ready(ordy64), .sum(s64), .cout(co64)
`ifdef PPA_OVF_EN
    , .ovf(of64)
`endif
  );

  // Reference: plain wide addition of a + b' + carry, masked to w bits
  function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                 input logic cin, input logic sub, input int w);
    exp_t        e;
    logic [63:0] mask, bb;
    logic [64:0] full;
    mask   = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    bb     = (sub ? ~b : b) & mask;
    full   = {1'b0, a & mask} + {1'b0, bb} + {64'd0, (sub | cin)};
    e.sum  = full[63:0] & mask;
    e.cout = full[w];
    e.ovf  = (a[w-1] == bb[w-1]) && (e.sum[w-1] != a[w-1]);
    return e;
  endfunction

  always @(negedge clk) begin : mon16
    exp_t e;
    if (rst_n) begin
      if (ov16 && ordy16) begin
        n_checks++; n_ret16++;
        if (q16.size() == 0) begin
          n_fail++; $display("FAIL w16_unexpected_result got sum=%h cout=%b", s16, co16);
        end else begin
          e = q16.pop_front();
          if (s16 !== e.sum[15:0] || co16 !== e.cout) begin
            n_fail++; $display("FAIL w16_result got sum=%h cout=%b want sum=%h cout=%b", s16, co16, e.sum[15:0], e.cout);
          end
`ifdef PPA_OVF_EN
          n_checks++;
          if (of16 !== e.ovf) begin n_fail++; $display("FAIL w16_ovf got %b want %b", of16, e.ovf); end
`endif
        end
      end
      if (iv16 && ir16) q16.push_back(model({48'd0, a16}, {48'd0, b16}, cin16, sub16, 16));
    end
  end

  always @(negedge clk) begin : mon8
    exp_t e;
    if (rst_n) begin
      if (ov8 && ordy8) begin
        n_checks++; n_ret8++;
        if (q8.size() == 0) begin
          n_fail++; $display("FAIL w8_unexpected_result got sum=%h cout=%b", s8, co8);
        end else begin
          e = q8.pop_front();
          if (s8 !== e.sum[7:0] || co8 !== e.cout) begin
            n_fail++; $display("FAIL w8_result got sum=%h cout=%b want sum=%h cout=%b", s8, co8, e.sum[7:0], e.cout);
          end
`ifdef PPA_OVF_EN
          n_checks++;
          if (of8 !== e.ovf) begin n_fail++; $display("FAIL w8_ovf got %b want %b", of8, e.ovf); end
`endif
        end
      end
      if (iv8 && ir8) q8.push_back(model({56'd0, a8}, {56'd0, b8}, cin8, sub8, 8));
    end
  end

  always @(negedge clk) begin : mon64
    exp_t e;
    if (rst_n) begin
      if (ov64 && ordy64) begin
        n_checks++; n_ret64++;
        if (q64.size() == 0) begin
          n_fail++; $display("FAIL w64_unexpected_result got sum=%h cout=%b", s64, co64);
        end else begin
          e = q64.pop_front();
          if (s64 !== e.sum || co64 !== e.cout) begin
            n_fail++; $display("FAIL w64_result got sum=%h cout=%b want sum=%h cout=%b", s64, co64, e.sum, e.cout);
          end
`ifdef PPA_OVF_EN
          n_checks++;
          if (of64 !== e.ovf) begin n_fail++; $display("FAIL w64_ovf got %b want %b", of64, e.ovf); end
`endif
        end
      end
      if (iv64 && ir64) q64.push_back(model(a64, b64, cin64, sub64, 64));
    end
  end

  task automatic test_reset();
    #2;
    n_checks++; if (ov16 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", ov16); end
    n_checks++; if (ir16 !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", ir16); end
    n_checks++; if (ov8 !== 1'b0 || ov64 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid_other got %b%b want 00", ov8, ov64); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (ov16 !== 1'b0 || ir16 !== 1'b1) begin n_fail++; $display("FAIL post_reset got ov=%b ir=%b want ov=0 ir=1", ov16, ir16); end
  endtask

  task automatic send_wait16(input logic [15:0] a_v, input logic [15:0] b_v,
                             input logic c_v, input logic s_v, output logic ok);
    @(posedge clk); #1;
    a16 = a_v; b16 = b_v; cin16 = c_v; sub16 = s_v; iv16 = 1'b1; ordy16 = 1'b1;
    @(posedge clk); #1 iv16 = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (ov16) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_add_latency();
    int lat;
    @(posedge clk); #1;
    a16 = 16'hFFFF; b16 = 16'h0001; cin16 = 1'b0; sub16 = 1'b0; iv16 = 1'b1; ordy16 = 1'b1;
    @(negedge clk);
    n_checks++; if (ir16 !== 1'b1) begin n_fail++; $display("FAIL add_in_ready got %b want 1", ir16); end
    @(posedge clk); #1 iv16 = 1'b0;
    // Cycles counted from the cycle in which the beat was accepted
    lat = 1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (ov16) break;
      @(posedge clk); #1 lat++;
    end
    n_checks++; if (lat != 2) begin n_fail++; $display("FAIL add_latency got %0d want 2", lat); end
    n_checks++;
    if (s16 !== 16'h0000 || co16 !== 1'b1) begin
      n_fail++; $display("FAIL add_ffff_plus_1 got sum=%h cout=%b want sum=0000 cout=1", s16, co16);
    end
  endtask

  task automatic test_sub();
    logic ok;
    send_wait16(16'h0005, 16'h0007, 1'b1, 1'b1, ok);
    n_checks++;
    if (!ok || s16 !== 16'hFFFE || co16 !== 1'b0) begin
      n_fail++; $display("FAIL sub_5_minus_7 got ok=%b sum=%h cout=%b want sum=fffe cout=0", ok, s16, co16);
    end
    send_wait16(16'h0007, 16'h0005, 1'b0, 1'b1, ok);
    n_checks++;
    if (!ok || s16 !== 16'h0002 || co16 !== 1'b1) begin
      n_fail++; $display("FAIL sub_7_minus_5 got ok=%b sum=%h cout=%b want sum=0002 cout=1", ok, s16, co16);
    end
    send_wait16(16'h1234, 16'h4321, 1'b1, 1'b0, ok);
    n_checks++;
    if (!ok || s16 !== 16'h5556 || co16 !== 1'b0) begin
      n_fail++; $display("FAIL add_with_cin got ok=%b sum=%h cout=%b want sum=5556 cout=0", ok, s16, co16);
    end
`ifdef PPA_OVF_EN
    send_wait16(16'h7FFF, 16'h0001, 1'b0, 1'b0, ok);
    n_checks++;
    if (!ok || s16 !== 16'h8000 || of16 !== 1'b1) begin
      n_fail++; $display("FAIL ovf_add got ok=%b sum=%h ovf=%b want sum=8000 ovf=1", ok, s16, of16);
    end
    send_wait16(16'h8000, 16'h0001, 1'b0, 1'b1, ok);
    n_checks++;
    if (!ok || s16 !== 16'h7FFF || of16 !== 1'b1) begin
      n_fail++; $display("FAIL ovf_sub got ok=%b sum=%h ovf=%b want sum=7fff ovf=1", ok, s16, of16);
    end
    send_wait16(16'h0001, 16'h0001, 1'b0, 1'b0, ok);
    n_checks++;
    if (!ok || of16 !== 1'b0) begin n_fail++; $display("FAIL ovf_none got ok=%b ovf=%b want 0", ok, of16); end
`endif
  endtask

  task automatic test_back_to_back();
    int vcnt, first, last;
    vcnt = 0; first = -1; last = -1;
    for (int c = 0; c < 14; c++) begin
      @(posedge clk); #1;
      iv16 = (c < 8); a16 = 16'(c); b16 = 16'(2*c); cin16 = 1'b0; sub16 = 1'b0; ordy16 = 1'b1;
      @(negedge clk);
      if (c < 8) begin
        n_checks++; if (ir16 !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready c=%0d got %b want 1", c, ir16); end
      end
      if (ov16) begin
        n_checks++;
        if (s16 !== 16'(3*vcnt)) begin n_fail++; $display("FAIL b2b_sum got %h want %h", s16, 16'(3*vcnt)); end
        vcnt++;
        if (first < 0) first = c;
        last = c;
      end
    end
    n_checks++; if (vcnt != 8) begin n_fail++; $display("FAIL b2b_count got %0d want 8", vcnt); end
    n_checks++; if (last - first != 7) begin n_fail++; $display("FAIL b2b_contiguous got span %0d want 7", last - first); end
  endtask

  task automatic test_backpressure();
    int acc, r0;
    logic [15:0] nxt;
    acc = 0; r0 = n_ret16; nxt = 16'd100;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      iv16 = 1'b1; a16 = nxt; b16 = nxt; cin16 = 1'b0; sub16 = 1'b0; ordy16 = 1'b0;
      @(negedge clk);
      if (ir16) begin acc++; nxt = nxt + 16'd1; end
      if (ov16) begin
        n_checks++; if (s16 !== 16'd200) begin n_fail++; $display("FAIL bp_hold got %h want 00c8", s16); end
      end
    end
    n_checks++; if (acc != 2) begin n_fail++; $display("FAIL bp_accepts got %0d want 2", acc); end
    n_checks++; if (ir16 !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready got %b want 0", ir16); end
    @(posedge clk); #1;
    a16 = nxt; b16 = nxt; ordy16 = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ir16 !== 1'b1 || ov16 !== 1'b1 || s16 !== 16'd200) begin
      n_fail++; $display("FAIL bp_release got ir=%b ov=%b sum=%h want ir=1 ov=1 sum=00c8", ir16, ov16, s16);
    end
    if (ir16) acc++;
    @(posedge clk); #1 iv16 = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    n_checks++; if (n_ret16 - r0 != acc) begin n_fail++; $display("FAIL bp_retired got %0d want %0d", n_ret16 - r0, acc); end
    n_checks++; if (q16.size() != 0) begin n_fail++; $display("FAIL bp_pending got %0d want 0", q16.size()); end
  endtask

  task automatic test_reset_flush();
    int seen;
    ordy16 = 1'b0;
    @(posedge clk); #1 iv16 = 1'b1; a16 = 16'h0101; b16 = 16'h0202; cin16 = 1'b0; sub16 = 1'b0;
    @(posedge clk); #1 a16 = 16'h0303;
    @(posedge clk); #1 iv16 = 1'b0;
    @(negedge clk);
    n_checks++; if (ov16 !== 1'b1) begin n_fail++; $display("FAIL flush_full got ov=%b want 1", ov16); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (ov16 !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid got %b want 0", ov16); end
    n_checks++; if (ir16 !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready got %b want 1", ir16); end
    q16.delete(); q8.delete(); q64.delete();
    @(posedge clk); #1 rst_n = 1'b1; ordy16 = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (ov16) seen++;
    end
    n_checks++; if (seen != 0) begin n_fail++; $display("FAIL flush_ghost got %0d results want 0", seen); end
  endtask

  task automatic test_random_sweep();
    int r16, r8, r64;
    r16 = n_ret16; r8 = n_ret8; r64 = n_ret64;
    for (int c = 0; c < 8000; c++) begin
      @(posedge clk); #1;
      iv16 = ($urandom_range(0, 3) != 0); a16 = 16'($urandom); b16 = 16'($urandom);
      cin16 = 1'($urandom); sub16 = 1'($urandom); ordy16 = ($urandom_range(0, 3) != 0);
      iv8 = ($urandom_range(0, 3) != 0); a8 = 8'($urandom); b8 = 8'($urandom);
      cin8 = 1'($urandom); sub8 = 1'($urandom); ordy8 = ($urandom_range(0, 3) != 0);
      iv64 = ($urandom_range(0, 3) != 0); a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom};
      cin64 = 1'($urandom); sub64 = 1'($urandom); ordy64 = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    iv16 = 1'b0; iv8 = 1'b0; iv64 = 1'b0; ordy16 = 1'b1; ordy8 = 1'b1; ordy64 = 1'b1;
    repeat (30) @(posedge clk);
    @(negedge clk);
    n_checks++; if (q16.size() != 0) begin n_fail++; $display("FAIL rand16_pending got %0d want 0", q16.size()); end
    n_checks++; if (q8.size() != 0) begin n_fail++; $display("FAIL rand8_pending got %0d want 0", q8.size()); end
    n_checks++; if (q64.size() != 0) begin n_fail++; $display("FAIL rand64_pending got %0d want 0", q64.size()); end
    n_checks++;
    if (n_ret16 - r16 < 1000 || n_ret8 - r8 < 1000 || n_ret64 - r64 < 1000) begin
      n_fail++; $display("FAIL rand_volume got %0d/%0d/%0d want >=1000 each", n_ret16 - r16, n_ret8 - r8, n_ret64 - r64);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    iv16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0; sub16 = 1'b0; ordy16 = 1'b1;
    iv8  = 1'b0; a8  = '0; b8  = '0; cin8  = 1'b0; sub8  = 1'b0; ordy8  = 1'b1;
    iv64 = 1'b0; a64 = '0; b64 = '0; cin64 = 1'b0; sub64 = 1'b0; ordy64 = 1'b1;
    test_reset();
    test_add_latency();
    test_sub();
    test_back_to_back();
    test_backpressure();
    test_reset_flush();
    test_random_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
